// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//   MEM-stage load/store sequencer between the pipeline and a valid/ok style
//   data bus. An access is captured in IDLE, issued in REQ (bus_req high
//   until bus_addr_ok), finished in WAIT (until bus_data_ok), and reported
//   by a one-cycle done_out pulse in DONE.
//
//   Ports
//     clk, rst         : clock, synchronous active-high reset
//     mem_*_in         : access request from the MEM stage (valid, we, size,
//                        sign, addr, low-aligned wdata)
//     stall_out        : holds EX/MEM while the access is outstanding
//     done_out         : access complete this cycle
//     load_data_out    : extended load result, held until the next load
//     ale_out          : alignment fault, valid with done_out
//     bus_*            : bus request channel (req/we/addr/wstrb/wdata out,
//                        addr_ok/data_ok/rdata in)
//
//   Configuration
//     MEM_ALIGN_CHECK_EN : when defined, misaligned half/word accesses skip
//                          the bus and complete with ale_out=1. When not
//                          defined, ale_out is tied 0 and the low address bits
//                          below the access size are ignored.
// ---------------------------------------------------------------------------
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    // pipeline side
    input  logic        mem_valid_in,
    input  logic        mem_we_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_sign_in,
    input  logic [31:0] mem_addr_in,
    input  logic [31:0] mem_wdata_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] load_data_out,
    output logic        ale_out,
    // bus side
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [31:0] r_load_data;

    logic        w_start;
    logic        w_misalign;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_data_cap;

    assign w_start = (r_state == S_IDLE) && mem_valid_in;

`ifdef MEM_ALIGN_CHECK_EN
    // size 11 is treated as word, so size[1] covers both word encodings
    assign w_misalign = (mem_size_in == 2'b01 && mem_addr_in[0]) ||
                        (mem_size_in[1] && (mem_addr_in[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Store lane strobes and data replicated across every lane so the bus
    // side only needs the strobes to place the data.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = mem_wdata_in;
        case (mem_size_in)
            2'b00: begin
                w_wstrb = 4'b0001 << mem_addr_in[1:0];
                w_wdata = {4{mem_wdata_in[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << {mem_addr_in[1], 1'b0};
                w_wdata = {2{mem_wdata_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select uses the latched address so late mem_* changes are
    // invisible to the access in flight.
    assign w_byte = bus_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = r_addr[1] ? bus_rdata[31:16] : bus_rdata[15:0];

    always_comb begin
        w_load = bus_rdata;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{r_sign & w_half[15]}}, w_half};
            default: w_load = bus_rdata;
        endcase
    end

    // data_ok only counts once the address phase has been accepted
    assign w_data_cap = bus_data_ok && !r_we &&
                        ((r_state == S_REQ && bus_addr_ok) || r_state == S_WAIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (mem_valid_in) w_next = w_misalign ? S_DONE : S_REQ;
            S_REQ:  if (bus_addr_ok)  w_next = bus_data_ok ? S_DONE : S_WAIT;
            S_WAIT: if (bus_data_ok)  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wstrb     <= 4'd0;
            r_wdata     <= 32'd0;
            r_size      <= 2'd0;
            r_sign      <= 1'b0;
            r_load_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_we    <= mem_we_in;
                r_addr  <= mem_addr_in;
                r_wstrb <= w_wstrb;
                r_wdata <= w_wdata;
                r_size  <= mem_size_in;
                r_sign  <= mem_sign_in;
            end
            if (w_data_cap)
                r_load_data <= w_load;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Fault flag lives exactly for the DONE cycle of a skipped access.
    logic r_ale;
    always_ff @(posedge clk) begin
        if (rst) r_ale <= 1'b0;
        else     r_ale <= w_start && w_misalign;
    end
    assign ale_out = r_ale;
`else
    assign ale_out = 1'b0;
`endif

    assign stall_out     = !rst && (w_start || r_state == S_REQ || r_state == S_WAIT);
    assign done_out      = (r_state == S_DONE);
    assign bus_req       = (r_state == S_REQ);
    assign bus_we        = r_we;
    assign bus_addr      = r_addr;
    assign bus_wstrb     = r_wstrb;
    assign bus_wdata     = r_wdata;
    assign load_data_out = r_load_data;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_in, mem_we_in, mem_sign_in;
    logic [1:0]  mem_size_in;
    logic [31:0] mem_addr_in, mem_wdata_in;
    logic        stall_out, done_out, ale_out;
    logic [31:0] load_data_out;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok, bus_data_ok;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid_in(mem_valid_in), .mem_we_in(mem_we_in),
        .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in),
        .mem_addr_in(mem_addr_in), .mem_wdata_in(mem_wdata_in),
        .stall_out(stall_out), .done_out(done_out),
        .load_data_out(load_data_out), .ale_out(ale_out),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load: addr_ok and data_ok both high in the single REQ cycle.
    task automatic load_zw(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] rd,
                           input logic [3:0] exp_strb, input logic [31:0] exp);
        mem_valid_in = 1'b1; mem_we_in = 1'b0; mem_size_in = sz;
        mem_sign_in = sg; mem_addr_in = a;
        tick;
        mem_valid_in = 1'b0;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = rd;
        #1;
        chk({tag, ".req"},  bus_req, 1);
        chk({tag, ".strb"}, bus_wstrb, exp_strb);
        tick;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        chk({tag, ".done"}, done_out, 1);
        chk({tag, ".data"}, load_data_out, exp);
        tick;
    endtask

    initial begin
        rst = 1'b1;
        mem_valid_in = 1'b0; mem_we_in = 1'b0; mem_size_in = 2'b00;
        mem_sign_in = 1'b0; mem_addr_in = 32'd0; mem_wdata_in = 32'd0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        tick;
        tick;
        mem_valid_in = 1'b1;
        #1;
        chk("rst.stall", stall_out, 0);
        chk("rst.req",   bus_req, 0);
        chk("rst.we",    bus_we, 0);
        chk("rst.addr",  bus_addr, 0);
        chk("rst.strb",  bus_wstrb, 0);
        chk("rst.wdata", bus_wdata, 0);
        chk("rst.load",  load_data_out, 0);
        chk("rst.done",  done_out, 0);
        chk("rst.ale",   ale_out, 0);
        mem_valid_in = 1'b0;
        tick;
        rst = 1'b0;

        // responses while idle must not start or finish anything
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555_5555;
        tick;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        chk("idle.req",  bus_req, 0);
        chk("idle.done", done_out, 0);
        chk("idle.load", load_data_out, 0);

        // load word 0x1000, zero-wait: stall 2 cycles, done on the 3rd
        mem_valid_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b10; mem_addr_in = 32'h1000;
        #1;
        chk("lw.c1.stall", stall_out, 1);
        chk("lw.c1.req",   bus_req, 0);
        tick;
        mem_valid_in = 1'b0; mem_addr_in = 32'hFFFF_FFFC;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw.c2.stall", stall_out, 1);
        chk("lw.c2.req",   bus_req, 1);
        chk("lw.c2.addr",  bus_addr, 32'h1000);
        chk("lw.c2.we",    bus_we, 0);
        chk("lw.c2.strb",  bus_wstrb, 4'hF);
        tick;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
        chk("lw.c3.done",  done_out, 1);
        chk("lw.c3.stall", stall_out, 0);
        chk("lw.c3.req",   bus_req, 0);
        chk("lw.c3.data",  load_data_out, 32'hDEAD_BEEF);
        tick;
        chk("lw.c4.done",  done_out, 0);

        // lane select and extension
        load_zw("lb.s",  32'h1003, 2'b00, 1'b1, 32'h80FF_FFFF, 4'b1000, 32'hFFFF_FF80);
        load_zw("lb.u",  32'h1003, 2'b00, 1'b0, 32'h80FF_FFFF, 4'b1000, 32'h0000_0080);
        load_zw("lh.s",  32'h1002, 2'b01, 1'b1, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        load_zw("lh.u",  32'h1000, 2'b01, 1'b0, 32'h8001_1234, 4'b0011, 32'h0000_1234);
        load_zw("lb.s1", 32'h1001, 2'b00, 1'b1, 32'h0000_7F00, 4'b0010, 32'h0000_007F);

        // store half 0x2002, addr_ok after 3 wait cycles, data_ok 2 cycles later
        mem_valid_in = 1'b1; mem_we_in = 1'b1; mem_size_in = 2'b01;
        mem_addr_in = 32'h2002; mem_wdata_in = 32'h0000_ABCD;
        tick;
        mem_valid_in = 1'b0; mem_addr_in = 32'hFFFF_FFFF; mem_wdata_in = 32'd0;
        mem_size_in = 2'b00; mem_we_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_addr_ok = (i == 3);
            #1;
            chk($sformatf("sh.req%0d", i),   bus_req, 1);
            chk($sformatf("sh.stall%0d", i), stall_out, 1);
            chk($sformatf("sh.strb%0d", i),  bus_wstrb, 4'b1100);
            chk($sformatf("sh.wdata%0d", i), bus_wdata, 32'hABCD_ABCD);
            chk($sformatf("sh.addr%0d", i),  bus_addr, 32'h2002);
            chk($sformatf("sh.we%0d", i),    bus_we, 1);
            tick;
        end
        bus_addr_ok = 1'b0;
        chk("sh.wait.req",   bus_req, 0);
        chk("sh.wait.stall", stall_out, 1);
        tick;
        chk("sh.wait2.stall", stall_out, 1);
        chk("sh.wait2.done",  done_out, 0);
        bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        tick;
        bus_data_ok = 1'b0;
        chk("sh.done",  done_out, 1);
        chk("sh.stall", stall_out, 0);
        chk("sh.load",  load_data_out, 32'h0000_007F);
        tick;

        // reset during WAIT abandons the access; the late data_ok is ignored
        mem_valid_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b10; mem_addr_in = 32'h3000;
        tick;
        mem_valid_in = 1'b0; bus_addr_ok = 1'b1;
        tick;
        bus_addr_ok = 1'b0;
        chk("rw.wait.req",   bus_req, 0);
        chk("rw.wait.stall", stall_out, 1);
        rst = 1'b1;
        #1;
        chk("rw.rst.stall", stall_out, 0);
        tick;
        rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("rw.idle.stall", stall_out, 0);
        tick;
        bus_data_ok = 1'b0;
        chk("rw.done", done_out, 0);
        chk("rw.req",  bus_req, 0);
        chk("rw.load", load_data_out, 0);
        tick;
        chk("rw.done2", done_out, 0);

`ifdef MEM_ALIGN_CHECK_EN
        // misaligned word load skips the bus and faults
        mem_valid_in = 1'b1; mem_we_in = 1'b0; mem_size_in = 2'b10; mem_addr_in = 32'h1002;
        #1;
        chk("ale.c1.stall", stall_out, 1);
        tick;
        mem_valid_in = 1'b0;
        chk("ale.req",   bus_req, 0);
        chk("ale.done",  done_out, 1);
        chk("ale.ale",   ale_out, 1);
        chk("ale.stall", stall_out, 0);
        chk("ale.load",  load_data_out, 0);
        tick;
        chk("ale.done2", done_out, 0);
        chk("ale.ale2",  ale_out, 0);
`else
        // no alignment check: word ignores addr[1:0], half ignores addr[0]
        load_zw("lw.mis", 32'h1002, 2'b10, 1'b0, 32'h1122_3344, 4'b1111, 32'h1122_3344);
        chk("lw.mis.ale", ale_out, 0);
        load_zw("lh.mis", 32'h1003, 2'b01, 1'b0, 32'hAABB_CCDD, 4'b1100, 32'h0000_AABB);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on posedge; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have pipeline-side inputs: mem_valid_in  in  1  MEM-stage access pending; mem_we_in  in  1  1=store, 0=load; mem_size_in  in  2  00 byte, 01 half, 10 word, 11 treated as word; mem_sign_in  in  1  sign-extend load; mem_addr_in  in  32  byte address; mem_wdata_in  in  32  store data, low-aligned.
REQ-003 SHALL have pipeline-side outputs: stall_out  out  1  drives the EX/MEM stall-from-DCache input; done_out  out  1  access complete this cycle; load_data_out  out  32  extended load result; ale_out  out  1  alignment fault.
REQ-004 SHALL have bus ports: bus_req  out  1; bus_we  out  1; bus_addr  out  32; bus_wstrb  out  4; bus_wdata  out  32; bus_addr_ok  in  1  request accepted; bus_data_ok  in  1  read data / write ack; bus_rdata  in  32.

Function
REQ-005 SHALL implement FSM IDLE, REQ, WAIT, DONE, state-encoded in registers.
REQ-006 IDLE: on mem_valid_in=1 SHALL register bus_we, bus_addr, bus_wstrb, bus_wdata and go to REQ; else stay.
REQ-007 REQ: bus_req=1; hold all bus outputs stable until bus_addr_ok; addr_ok alone -> WAIT; addr_ok and data_ok same cycle -> DONE.
REQ-008 WAIT: bus_req=0; on bus_data_ok -> DONE; stores also wait for data_ok.
REQ-009 DONE: done_out=1 for exactly one cycle; unconditionally -> IDLE.
REQ-010 stall_out SHALL be combinational: (IDLE & mem_valid_in) | REQ | WAIT; 0 in DONE and while rst=1.
REQ-011 Minimum latency with zero-wait bus: stall_out high 2 cycles, done_out on 3rd cycle after mem_valid_in first seen.
REQ-012 Store wstrb: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; bus_wdata byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-013 Load: lane select by addr[1:0] (byte) or addr[1] (half); zero- or sign-extend per mem_sign_in; captured into load_data_out on the data_ok cycle; held until next capture; stores leave it unchanged.
REQ-014 bus_data_ok or bus_addr_ok in IDLE or DONE SHALL be ignored.
REQ-015 bus_we, bus_addr latched once per access; mem_* input changes after IDLE capture SHALL not affect the access.

Reset
REQ-016 rst=1 SHALL force IDLE and clear bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, load_data_out, done_out, ale_out to 0, next edge.
REQ-017 rst mid-access (REQ/WAIT) SHALL abandon the access; late bus responses ignored per REQ-014.

Configuration
REQ-018 Macro MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL skip bus (IDLE -> DONE, bus_req never asserted), ale_out=1 and done_out=1 in DONE, load_data_out unchanged; stall_out high 1 cycle.
REQ-019 Macro undefined: no check; ale_out tied 0; half ignores addr[0], word ignores addr[1:0] for lane and strobe.

Verification
REQ-020 Load word, addr 0x1000, zero-wait bus, rdata 0xDEADBEEF -> bus_req 1 cycle, stall 2 cycles, done_out then load_data_out=0xDEADBEEF.
REQ-021 Load byte signed, addr 0x1003, rdata 0x80FFFFFF -> load_data_out=0xFFFFFF80; unsigned -> 0x00000080.
REQ-022 Store half, addr 0x2002, wdata 0x0000ABCD, addr_ok delayed 3 cycles -> bus_req held 4 cycles, wstrb=1100, bus_wdata=0xABCDABCD, stall until data_ok.
REQ-023 rst asserted in WAIT, then data_ok pulse -> IDLE, bus_req=0, done_out never pulses, load_data_out=0.
REQ-024 With MEM_ALIGN_CHECK_EN, load word addr 0x1002 -> no bus_req, ale_out=1 with done_out=1 next cycle; without macro -> normal access, wstrb/lane as word.
